instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the main controller. It owns the program counter and reads instruction words from instruction memory over a request/ready handshake. It holds each fetched word in the instruction register and presents it, with its opcode field and i_odv, until the controller consumes it. The controller's extra-word waits (second fetch, interrupt vector load) use the same fetch_req/i_ack/pc_ld path.

---
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over an im_rd/im_rdy handshake and holds the word in ir until the controller acks it.
// Optional macro FETCH_TIMEOUT_EN adds a watchdog on the memory read and a sticky fetch_err flag.
module instr_fetch_unit #(
    parameter int unsigned          ADDR_W   = 16,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          OPC_W    = 6,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter int unsigned          TIMEOUT  = 255
) (
    input  logic              g_clk,
    input  logic              g_clr,
    input  logic              fetch_req,
    input  logic              i_ack,
    input  logic              pc_ld,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [DATA_W-1:0] im_rdata,
    input  logic              im_rdy,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_rd,
    output logic [DATA_W-1:0] ir,
    output logic [OPC_W-1:0]  opcode,
    output logic              i_odv,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err
);

    typedef enum logic [1:0] {IDLE, RD, VALID} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc_nxt, pend_pc, pend_pc_nxt;
    logic [DATA_W-1:0]  ir_nxt;
    logic               flush_pend, flush_pend_nxt;
    logic               timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err_q;

    // Counter is zero outside RD, so every entry into RD starts a fresh count.
    always_comb begin
        cnt_nxt     = '0;
        timeout_hit = 1'b0;
        if (state == RD && !im_rdy) begin
            if (cnt == CNT_W'(TIMEOUT - 1)) timeout_hit = 1'b1;
            else                            cnt_nxt     = cnt + 1'b1;
        end
    end

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            err_q <= err_q | timeout_hit;
        end
    end

    assign fetch_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            pend_pc    <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            ir         <= ir_nxt;
            pend_pc    <= pend_pc_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        ir_nxt         = ir;
        pend_pc_nxt    = pend_pc;
        flush_pend_nxt = flush_pend;
        unique case (state)
            IDLE: begin
                if (pc_ld)     pc_nxt    = pc_in;
                if (fetch_req) state_nxt = RD;
            end
            RD: begin
                if (pc_ld) begin
                    pend_pc_nxt    = pc_in;
                    flush_pend_nxt = 1'b1;
                end
                if (im_rdy) begin
                    // A redirect seen in the same cycle as the data still kills that word.
                    if (flush_pend || pc_ld) begin
                        pc_nxt         = pc_ld ? pc_in : pend_pc;
                        flush_pend_nxt = 1'b0;
                        state_nxt      = IDLE;
                    end else begin
                        pc_nxt    = pc + 1'b1;
                        ir_nxt    = im_rdata;
                        state_nxt = VALID;
                    end
                end else if (timeout_hit) begin
                    flush_pend_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            VALID: begin
                if (pc_ld) begin
                    pc_nxt    = pc_in;
                    state_nxt = fetch_req ? RD : IDLE;
                end else if (i_ack) begin
                    state_nxt = fetch_req ? RD : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign im_addr = pc;
    assign im_rd   = (state == RD);
    assign i_odv   = (state == VALID);
    assign opcode  = ir[DATA_W-1 -: OPC_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (RESET_PC=0x0040; TIMEOUT=8 when FETCH_TIMEOUT_EN is defined).
module tb_instr_fetch_unit;

    logic        g_clk = 1'b0;
    logic        g_clr = 1'b1;
    logic        fetch_req = 1'b0, i_ack = 1'b0, pc_ld = 1'b0, im_rdy = 1'b0;
    logic [15:0] pc_in = '0;
    logic [31:0] im_rdata = '0;
    logic [15:0] im_addr, pc;
    logic        im_rd, i_odv, fetch_err;
    logic [31:0] ir;
    logic [5:0]  opcode;

    int checks = 0;
    int failures = 0;

    always #5 g_clk = ~g_clk;

    instr_fetch_unit #(
        .ADDR_W(16), .DATA_W(32), .OPC_W(6), .RESET_PC(16'h0040), .TIMEOUT(8)
    ) dut (
        .g_clk(g_clk), .g_clr(g_clr), .fetch_req(fetch_req), .i_ack(i_ack),
        .pc_ld(pc_ld), .pc_in(pc_in), .im_rdata(im_rdata), .im_rdy(im_rdy),
        .im_addr(im_addr), .im_rd(im_rd), .ir(ir), .opcode(opcode),
        .i_odv(i_odv), .pc(pc), .fetch_err(fetch_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle_in();
        fetch_req = 0; i_ack = 0; pc_ld = 0; im_rdy = 0;
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_im_rd", im_rd, 0);
        chk("rst_odv", i_odv, 0);
        chk("rst_pc", pc, 16'h0040);
        chk("rst_ir", ir, 0);
        chk("rst_err", fetch_err, 0);
        g_clr = 0;
        tick();

        // zero-wait fetch
        fetch_req = 1; tick();
        chk("f1_im_rd", im_rd, 1);
        chk("f1_addr", im_addr, 16'h0040);
        fetch_req = 0; im_rdy = 1; im_rdata = 32'h0C00_1234; tick();
        chk("f1_ir", ir, 32'h0C00_1234);
        chk("f1_opc", opcode, 6'o03);
        chk("f1_odv", i_odv, 1);
        chk("f1_pc", pc, 16'h0041);
        chk("f1_rd_drop", im_rd, 0);
        im_rdy = 0; im_rdata = 32'hDEAD_BEEF; fetch_req = 1; tick();
        fetch_req = 0; tick();
        chk("f1_hold_odv", i_odv, 1);
        chk("f1_hold_ir", ir, 32'h0C00_1234);
        chk("f1_ignore_req", im_rd, 0);
        i_ack = 1; tick(); i_ack = 0;
        chk("f1_ack_odv", i_odv, 0);
        chk("f1_ack_rd", im_rd, 0);

        // three wait states, then back-to-back ack+fetch
        fetch_req = 1; tick(); fetch_req = 0;
        for (int i = 0; i < 3; i++) begin
            chk("w_rd", im_rd, 1);
            chk("w_addr", im_addr, 16'h0041);
            chk("w_odv", i_odv, 0);
            tick();
        end
        chk("w_rd4", im_rd, 1);
        im_rdy = 1; im_rdata = 32'hFC00_0001; tick(); im_rdy = 0;
        chk("w_odv", i_odv, 1);
        chk("w_opc", opcode, 6'h3F);
        chk("w_pc", pc, 16'h0042);
        i_ack = 1; fetch_req = 1; tick(); idle_in();
        chk("b2b_rd", im_rd, 1);
        chk("b2b_odv", i_odv, 0);
        chk("b2b_addr", im_addr, 16'h0042);

        // redirect during RD wait: word discarded
        pc_ld = 1; pc_in = 16'h0100; tick(); pc_ld = 0;
        chk("fl_rd", im_rd, 1);
        chk("fl_addr", im_addr, 16'h0042);
        tick();
        im_rdy = 1; im_rdata = 32'h1111_1111; tick(); im_rdy = 0;
        chk("fl_odv", i_odv, 0);
        chk("fl_rd_drop", im_rd, 0);
        chk("fl_pc", pc, 16'h0100);
        tick();
        chk("fl_odv2", i_odv, 0);
        fetch_req = 1; tick(); fetch_req = 0;
        chk("fl_next_addr", im_addr, 16'h0100);
        chk("fl_next_rd", im_rd, 1);
        im_rdy = 1; im_rdata = 32'h1234_5678; tick(); im_rdy = 0;
        chk("fl_next_ir", ir, 32'h1234_5678);
        chk("fl_next_opc", opcode, 6'h04);
        chk("fl_next_pc", pc, 16'h0101);
        i_ack = 1; tick(); i_ack = 0;

        // redirect in the same cycle as im_rdy
        fetch_req = 1; tick(); fetch_req = 0;
        pc_ld = 1; pc_in = 16'h0200; im_rdy = 1; im_rdata = 32'h2222_2222; tick(); idle_in();
        chk("sc_odv", i_odv, 0);
        chk("sc_pc", pc, 16'h0200);
        chk("sc_ir_kept", ir, 32'h1234_5678);

        // pc_ld + fetch_req in IDLE, then wrap at 0xFFFF
        pc_ld = 1; pc_in = 16'hFFFF; fetch_req = 1; tick(); idle_in();
        chk("wr_addr", im_addr, 16'hFFFF);
        chk("wr_rd", im_rd, 1);
        im_rdy = 1; im_rdata = 32'hAAAA_5555; tick(); im_rdy = 0;
        chk("wr_pc", pc, 16'h0000);
        chk("wr_opc", opcode, 6'h2A);
        chk("wr_odv", i_odv, 1);
        // pc_ld in VALID flushes, i_ack ignored that cycle
        pc_ld = 1; pc_in = 16'h0300; i_ack = 1; tick(); idle_in();
        chk("vf_odv", i_odv, 0);
        chk("vf_pc", pc, 16'h0300);
        chk("vf_rd", im_rd, 0);

        // async reset mid-fetch
        fetch_req = 1; tick(); fetch_req = 0;
        chk("ar_rd_pre", im_rd, 1);
        #2 g_clr = 1; #1;
        chk("ar_rd", im_rd, 0);
        chk("ar_odv", i_odv, 0);
        chk("ar_pc", pc, 16'h0040);
        im_rdy = 1; im_rdata = 32'h3333_3333; tick();
        g_clr = 0; tick(); tick(); im_rdy = 0; tick();
        chk("ar_no_odv", i_odv, 0);
        chk("ar_no_rd", im_rd, 0);
        chk("ar_ir", ir, 0);

        // stalled memory
        fetch_req = 1; tick(); fetch_req = 0;
`ifdef FETCH_TIMEOUT_EN
        chk("to_rd0", im_rd, 1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("to_rd", im_rd, 1);
        end
        tick();
        chk("to_drop", im_rd, 0);
        chk("to_err", fetch_err, 1);
        chk("to_pc", pc, 16'h0040);
        fetch_req = 1; tick(); fetch_req = 0;
        im_rdy = 1; im_rdata = 32'h0400_0000; tick(); im_rdy = 0;
        chk("to_odv", i_odv, 1);
        chk("to_err_sticky", fetch_err, 1);
        g_clr = 1; tick(); g_clr = 0;
        chk("to_err_clr", fetch_err, 0);
`else
        for (int i = 0; i < 1000; i++) begin
            chk("nt_rd", im_rd, 1);
            chk("nt_err", fetch_err, 0);
            tick();
        end
        im_rdy = 1; im_rdata = 32'h0400_0000; tick(); im_rdy = 0;
        chk("nt_odv", i_odv, 1);
        chk("nt_pc", pc, 16'h0041);
        chk("nt_err_end", fetch_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
